serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing diff = a - b - bin over WIDTH clock cycles.
- Uses one full-subtractor cell and a registered borrow, processing operands LSB first.
- Counterpart to the combinational adder cells in the arithmetic library; used where area matters more than latency.
- start/busy/done handshake; results held in output registers until the next accepted start.

---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor, diff = a - b - bin,
//            one full-subtractor cell, LSB first, WIDTH cycles per result.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               last;

  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-2:0]   r_sr;     // upper result bits collected so far
  logic               borrow;
  logic [CNT_W-1:0]   cnt;

  logic               x;
  logic               y;
  logic               d;
  logic               borrow_next;
  logic [WIDTH-1:0]   res;

  // Full-subtractor cell on the current LSBs
  assign x           = a_sr[0];
  assign y           = b_sr[0];
  assign d           = x ^ y ^ borrow;
  assign borrow_next = (~x & y) | (~(x ^ y) & borrow);
  assign res         = {d, r_sr};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign last = (state == SHIFT) && (cnt == LAST_CNT);

  // Next-state logic; a start is honoured only when not busy
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand load and per-bit shift datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr   <= res[WIDTH-1:1];
      borrow <= borrow_next;
      cnt    <= last ? '0 : cnt + 1'b1;
    end
  end

  // Result registers update only on the edge processing the MSB; there
  // x and y are the operand sign bits captured at start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (last) begin
      diff <= res;
      bout <= borrow_next;
      ovf  <= (x ^ y) & (d ^ x);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed and reference-model checks of serial_subtractor at
//            WIDTH=8 and WIDTH=13.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bin8 = 1'b0;
  logic        busy8, done8, bout8, ovf8;
  logic [7:0]  diff8;

  logic        start13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0;
  logic        bin13 = 1'b0;
  logic        busy13, done13, bout13, ovf13;
  logic [12:0] diff13;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .bin(bin13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .ovf(ovf13)
  );

  // Present operands with start for one edge, then scramble the inputs
  task automatic start_op8(input logic [7:0] va, input logic [7:0] vb, input logic vbin);
    a8 = va; b8 = vb; bin8 = vbin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~va; b8 = ~vb; bin8 = ~vbin;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_done13(output int cyc);
    cyc = 0;
    while (done13 !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      n_err++;
      $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy8, done8, diff8, bout8, ovf8);
    end
    n_cmp++;
    if ({busy13, done13, diff13, bout13, ovf13} !== 17'h0) begin
      n_err++;
      $display("FAIL reset13: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy13, done13, diff13, bout13, ovf13);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [7:0] ta   [5] = '{8'h50, 8'h20, 8'h00, 8'h80, 8'h7F};
    logic [7:0] tb   [5] = '{8'h20, 8'h50, 8'h00, 8'h01, 8'hFF};
    logic       tbin [5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    logic [7:0] ed   [5] = '{8'h30, 8'hD0, 8'hFF, 8'h7F, 8'h80};
    logic       eb   [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic       eo   [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      start_op8(ta[i], tb[i], tbin[i]);
      n_cmp++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_busy: got busy=%b done=%b, want busy=1 done=0", i, busy8, done8);
      end
      wait_done8(cyc);
      n_cmp++;
      if (cyc != 8 || busy8 !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d cycles busy=%b, want 8 cycles busy=0", i, cyc, busy8);
      end
      n_cmp++;
      if ({diff8, bout8, ovf8} !== {ed[i], eb[i], eo[i]}) begin
        n_err++;
        $display("FAIL dir%0d_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                 i, diff8, bout8, ovf8, ed[i], eb[i], eo[i]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== ed[i]) begin
        n_err++;
        $display("FAIL dir%0d_after: got done=%b busy=%b diff=%h, want done=0 busy=0 diff=%h",
                 i, done8, busy8, diff8, ed[i]);
      end
    end
  endtask

  task automatic test_ignore_and_back_to_back;
    int cyc;
    start_op8(8'h10, 8'h01, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n_cmp++;
    if (diff8 !== 8'h80 || bout8 !== 1'b1 || ovf8 !== 1'b1) begin
      n_err++;
      $display("FAIL hold_midop: got diff=%h bout=%b ovf=%b, want diff=80 bout=1 ovf=1",
               diff8, bout8, ovf8);
    end
    wait_done8(cyc);
    n_cmp++;
    if (cyc != 5) begin
      n_err++;
      $display("FAIL ignore_latency: got %0d remaining cycles, want 5", cyc);
    end
    n_cmp++;
    if ({diff8, bout8, ovf8} !== {8'h0F, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL ignore_result: got diff=%h bout=%b ovf=%b, want diff=0f bout=0 ovf=0",
               diff8, bout8, ovf8);
    end
    // Start held during the done cycle is accepted immediately
    a8 = 8'h05; b8 = 8'h07; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    n_cmp++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy8, done8);
    end
    wait_done8(cyc);
    n_cmp++;
    if (cyc != 8) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d cycles, want 8", cyc);
    end
    n_cmp++;
    if ({diff8, bout8, ovf8} !== {8'hFE, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_result: got diff=%h bout=%b ovf=%b, want diff=fe bout=1 ovf=0",
               diff8, bout8, ovf8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int cyc;
    int dones;
    start_op8(8'h50, 8'h20, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_midop: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy8, done8, diff8, bout8, ovf8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_nodone: got %0d done pulses, want 0", dones);
    end
    start_op8(8'h33, 8'h11, 1'b1);
    wait_done8(cyc);
    n_cmp++;
    if (cyc != 8 || {diff8, bout8, ovf8} !== {8'h21, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_recover: got cyc=%0d diff=%h bout=%b ovf=%b, want cyc=8 diff=21 bout=0 ovf=0",
               cyc, diff8, bout8, ovf8);
    end
    @(posedge clk); #1;
  endtask

  // Each new start is issued in the previous done cycle, so the done
  // spacing is exactly the measured latency plus one
  task automatic test_random8;
    int cyc;
    logic [7:0] ra, rb;
    logic       rbin;
    logic [8:0] full;
    logic       eovf;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      start_op8(ra, rb, rbin);
      wait_done8(cyc);
      full = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
      eovf = (ra[7] != rb[7]) && (full[7] != ra[7]);
      n_cmp++;
      if (cyc != 8) begin
        n_err++;
        $display("FAIL rnd8_latency[%0d]: got %0d cycles, want 8", i, cyc);
      end
      n_cmp++;
      if ({diff8, bout8, ovf8} !== {full[7:0], full[8], eovf}) begin
        n_err++;
        $display("FAIL rnd8[%0d] a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                 i, ra, rb, rbin, diff8, bout8, ovf8, full[7:0], full[8], eovf);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random13;
    int cyc;
    logic [12:0] ra, rb;
    logic        rbin;
    logic [13:0] full;
    logic        eovf;
    for (int i = 0; i < 1000; i++) begin
      ra = 13'($urandom); rb = 13'($urandom); rbin = 1'($urandom);
      if (i == 0) begin ra = 13'h0000; rb = 13'h1FFF; rbin = 1'b1; end
      if (i == 1) begin ra = 13'h1000; rb = 13'h0001; rbin = 1'b0; end
      a13 = ra; b13 = rb; bin13 = rbin; start13 = 1'b1;
      @(posedge clk); #1;
      start13 = 1'b0; a13 = ~ra; b13 = ~rb; bin13 = ~rbin;
      wait_done13(cyc);
      full = {1'b0, ra} - {1'b0, rb} - {13'b0, rbin};
      eovf = (ra[12] != rb[12]) && (full[12] != ra[12]);
      n_cmp++;
      if (cyc != 13) begin
        n_err++;
        $display("FAIL rnd13_latency[%0d]: got %0d cycles, want 13", i, cyc);
      end
      n_cmp++;
      if ({diff13, bout13, ovf13} !== {full[12:0], full[13], eovf}) begin
        n_err++;
        $display("FAIL rnd13[%0d] a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                 i, ra, rb, rbin, diff13, bout13, ovf13, full[12:0], full[13], eovf);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_and_back_to_back();
    test_reset_midop();
    test_random8();
    test_random13();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
